// File: rtl/fm_modulate.sv
// ---------------------------------------------------------------------------
// fm_modulate
//
// Transmit-side FM modulator. Each accepted signed audio sample is scaled by
// the deviation shift (sw) and integrated into a 16-bit phase accumulator
// (65536 = 2*pi). The new phase is turned into an I/Q pair by an iterative
// rotation-mode CORDIC that runs one micro-rotation per clock. Only one
// sample is in flight at a time: the input is not ready while a rotation is
// running or while a result is waiting for the downstream handshake.
//
// Ports
//   s00_axis_aclk     in   sole clock, rising edge
//   s00_axis_aresetn  in   asynchronous active-low reset
//   s00_axis_tvalid   in   input sample valid
//   s00_axis_tlast    in   input packet end, forwarded with the sample
//   s00_axis_tdata    in   [15:0] signed audio sample, upper bits ignored
//   s00_axis_tstrb    in   ignored
//   s00_axis_tready   out  input ready (IDLE only, low during reset)
//   m00_axis_tready   in   downstream ready
//   sw                in   deviation shift, sampled with the input sample
//   m00_axis_tvalid   out  output valid
//   m00_axis_tlast    out  tlast of the sample being presented
//   m00_axis_tdata    out  [31:16] Q signed, [15:0] I signed
//   m00_axis_tstrb    out  all ones while tvalid is high, zero otherwise
// ---------------------------------------------------------------------------
module fm_modulate #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int ITERS                  = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  input  logic [3:0]                          sw,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int M_STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

  // Iteration counter value of the final micro-rotation.
  localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

  // Starting x magnitude; the CORDIC gain (~1.6468) brings it to ~32764.
  localparam logic signed [17:0] X_INIT = 18'sd19896;

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  logic [1:0]                        r_state;
  logic [15:0]                       r_phase;
  logic signed [17:0]                r_x;
  logic signed [17:0]                r_y;
  logic signed [16:0]                r_z;
  logic [3:0]                        r_iter;
  logic                              r_last;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_tdata;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic               w_accept;
  logic signed [15:0] w_audio;
  logic signed [15:0] w_step;
  logic [15:0]        w_nextPhase;
  logic               w_quad;
  logic [15:0]        w_z0;
  logic signed [17:0] w_xInit;
  logic signed [17:0] w_xShift;
  logic signed [17:0] w_yShift;
  logic signed [17:0] w_xNext;
  logic signed [17:0] w_yNext;
  logic signed [16:0] w_zNext;
  logic signed [16:0] w_atan;
  logic               w_dPos;
  logic               w_unused;

  // Only the low 16 bits carry audio; the rest of the beat is don't-care.
  assign w_unused = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};

  // -------------------------------------------------------------------------
  // arctangent table, 65536 = 2*pi
  // -------------------------------------------------------------------------
  function automatic logic signed [16:0] atanLookup(input logic [3:0] idx);
    logic signed [16:0] v;
    case (idx)
      4'd0:    v = 17'sd8192;
      4'd1:    v = 17'sd4836;
      4'd2:    v = 17'sd2555;
      4'd3:    v = 17'sd1297;
      4'd4:    v = 17'sd651;
      4'd5:    v = 17'sd326;
      4'd6:    v = 17'sd163;
      4'd7:    v = 17'sd81;
      4'd8:    v = 17'sd41;
      4'd9:    v = 17'sd20;
      4'd10:   v = 17'sd10;
      4'd11:   v = 17'sd5;
      4'd12:   v = 17'sd3;
      4'd13:   v = 17'sd1;
      4'd14:   v = 17'sd1;
      default: v = 17'sd0;
    endcase
    return v;
  endfunction

  // Clamp an 18-bit internal value to the signed 16-bit output range.
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    logic [15:0] r;
    if (v > 18'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -18'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Input side: accept, phase integration and quadrant pre-rotation
  // -------------------------------------------------------------------------
  assign s00_axis_tready = (r_state == S_IDLE) && s00_axis_aresetn;
  assign w_accept        = s00_axis_tvalid && s00_axis_tready;

  assign w_audio     = s00_axis_tdata[15:0];
  assign w_step      = w_audio >>> sw;
  // Modular 16-bit add: the phase wraps naturally at 2*pi.
  assign w_nextPhase = r_phase + w_step;

  // Angles in the left half-plane are rotated by pi up front (negate x and
  // subtract 32768 from z) so the CORDIC only has to cover +-pi/2.
  // Subtracting 32768 modulo 65536 is just an MSB flip.
  assign w_quad  = w_nextPhase[15] ^ w_nextPhase[14];
  assign w_z0    = w_quad ? (w_nextPhase ^ 16'h8000) : w_nextPhase;
  assign w_xInit = w_quad ? -X_INIT : X_INIT;

  // -------------------------------------------------------------------------
  // One CORDIC micro-rotation per cycle, direction chosen by the sign of z
  // -------------------------------------------------------------------------
  assign w_xShift = r_x >>> r_iter;
  assign w_yShift = r_y >>> r_iter;
  assign w_atan   = atanLookup(r_iter);
  assign w_dPos   = ~r_z[16];

  assign w_xNext = w_dPos ? (r_x - w_yShift) : (r_x + w_yShift);
  assign w_yNext = w_dPos ? (r_y + w_xShift) : (r_y - w_xShift);
  assign w_zNext = w_dPos ? (r_z - w_atan)   : (r_z + w_atan);

  // -------------------------------------------------------------------------
  // Control FSM and datapath registers. Reset discards any in-flight sample
  // and restarts the phase integrator from zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= S_IDLE;
      r_phase <= 16'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= 4'd0;
      r_last  <= 1'b0;
      r_tdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_phase <= w_nextPhase;
            r_x     <= w_xInit;
            r_y     <= '0;
            r_z     <= {w_z0[15], w_z0};
            r_iter  <= 4'd0;
            r_last  <= s00_axis_tlast;
            r_state <= S_ROT;
          end
        end
        S_ROT: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          if (r_iter == LAST_ITER) begin
            // Capture the saturated result straight from the final rotation
            // so it is valid in the very first OUT cycle.
            r_tdata        <= '0;
            r_tdata[31:16] <= sat16(w_yNext);
            r_tdata[15:0]  <= sat16(w_xNext);
            r_iter         <= 4'd0;
            r_state        <= S_OUT;
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end
        S_OUT: begin
          if (m00_axis_tready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output side: everything is decoded from registered state, so there is
  // no combinational path from m00_axis_tready to s00_axis_tready.
  // -------------------------------------------------------------------------
  assign m00_axis_tvalid = (r_state == S_OUT);
  assign m00_axis_tlast  = m00_axis_tvalid & r_last;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = m00_axis_tvalid ? {M_STRB_W{1'b1}} : '0;

endmodule

// File: tb/tb_fm_modulate.sv
// ---------------------------------------------------------------------------
// tb_fm_modulate
//
// Self-checking bench for fm_modulate. A reference model integrates the
// audio into a phase and predicts I/Q as 32764*cos/sin of that phase.
// ---------------------------------------------------------------------------
module tb_fm_modulate;

  localparam int LATENCY      = 16;
  localparam int PERIOD       = 18;
  localparam int TOL_DIRECTED = 4;
  localparam int TOL_RANDOM   = 24;
  localparam int WAIT_LIMIT   = 60;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        s00Tvalid;
  logic        s00Tlast;
  logic [31:0] s00Tdata;
  logic [3:0]  s00Tstrb;
  logic        s00Tready;
  logic        m00Tready;
  logic [3:0]  sw;
  logic        m00Tvalid;
  logic        m00Tlast;
  logic [31:0] m00Tdata;
  logic [3:0]  m00Tstrb;

  int checks = 0;
  int errors = 0;
  int modelPhase = 0;

  always #5 clk = ~clk;

  fm_modulate #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .ITERS(16)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(aresetn),
    .s00_axis_tvalid (s00Tvalid),
    .s00_axis_tlast  (s00Tlast),
    .s00_axis_tdata  (s00Tdata),
    .s00_axis_tstrb  (s00Tstrb),
    .s00_axis_tready (s00Tready),
    .m00_axis_tready (m00Tready),
    .sw              (sw),
    .m00_axis_tvalid (m00Tvalid),
    .m00_axis_tlast  (m00Tlast),
    .m00_axis_tdata  (m00Tdata),
    .m00_axis_tstrb  (m00Tstrb)
  );

  // Reference model: ideal rotation of the nominal amplitude.
  function automatic int roundReal(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return $rtoi(v - 0.5);
  endfunction

  function automatic void expectedIQ(input int phase, output int expI, output int expQ);
    real ang;
    ang  = 2.0 * 3.14159265358979 * real'(phase) / 65536.0;
    expI = roundReal(32764.0 * $cos(ang));
    expQ = roundReal(32764.0 * $sin(ang));
  endfunction

  function automatic int advancePhase(input int phase, input logic signed [15:0] audio,
                                      input logic [3:0] shift);
    int a;
    a = audio;
    a = a >>> shift;
    return (phase + a) & 32'h0000FFFF;
  endfunction

  task automatic checkExact(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected,
                            input int tol);
    int diff;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= tol) === 1'b1)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  task automatic checkOutput(input string tag, input int phase, input int tol,
                             input logic expLast);
    int eI, eQ, oI, oQ;
    expectedIQ(phase, eI, eQ);
    oI = int'($signed(m00Tdata[15:0]));
    oQ = int'($signed(m00Tdata[31:16]));
    checkValue({tag, ".I"}, oI, eI, tol);
    checkValue({tag, ".Q"}, oQ, eQ, tol);
    checkExact({tag, ".last"}, 64'(m00Tlast), 64'(expLast));
    checkExact({tag, ".strb"}, 64'(m00Tstrb), 64'(4'hF));
  endtask

  // Offer one sample and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic signed [15:0] audio, input logic [3:0] shift,
                               input logic last);
    int waited;
    waited    = 0;
    s00Tdata  = {16'($urandom), audio};
    sw        = shift;
    s00Tlast  = last;
    s00Tvalid = 1'b1;
    while (s00Tready !== 1'b1 && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    checkExact("acceptReady", 64'(s00Tready), 64'(1'b1));
    if (s00Tready === 1'b1) begin
      @(posedge clk); #1;
      modelPhase = advancePhase(modelPhase, audio, shift);
    end
    s00Tvalid = 1'b0;
    s00Tlast  = 1'b0;
    sw        = 4'($urandom);
  endtask

  // Count edges from the accept edge to the first valid output cycle.
  task automatic waitForOutput(input string tag);
    int n;
    n = 0;
    while (m00Tvalid !== 1'b1 && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkExact({tag, ".latency"}, 64'(n), 64'(LATENCY));
  endtask

  // Full sample with m00 ready high: accept, latency, data, handover.
  task automatic runSample(input string tag, input logic signed [15:0] audio,
                           input logic [3:0] shift, input logic last, input int tol);
    m00Tready = 1'b1;
    applyStimulus(audio, shift, last);
    waitForOutput(tag);
    checkOutput(tag, modelPhase, tol, last);
    @(posedge clk); #1;
    checkExact({tag, ".handover"}, 64'({m00Tvalid, s00Tready}), 64'(2'b01));
  endtask

  initial begin
    int phaseQ[$];
    logic lastQ[$];
    int acceptCyc[$];
    int validCyc[$];
    int cycle;
    logic acceptNext;
    logic [31:0] heldData;
    logic heldLast;
    int rises;

    aresetn   = 1'b0;
    s00Tvalid = 1'b0;
    s00Tlast  = 1'b0;
    s00Tdata  = '0;
    s00Tstrb  = 4'hF;
    m00Tready = 1'b1;
    sw        = 4'd0;

    // Reset state
    #1;
    checkExact("resetOutputs", 64'({m00Tvalid, m00Tlast, m00Tdata, m00Tstrb, s00Tready}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkExact("resetHeldReady", 64'(s00Tready), 64'(1'b0));
    aresetn = 1'b1;
    #1;
    checkExact("readyAfterRelease", 64'(s00Tready), 64'(1'b1));

    // First sample after reset and the quadrant walk
    runSample("first", 16'sd0, 4'd0, 1'b0, TOL_DIRECTED);
    runSample("quad90", 16'sd16384, 4'd0, 1'b1, TOL_DIRECTED);
    runSample("quad180", 16'sd16384, 4'd0, 1'b0, TOL_DIRECTED);
    runSample("quad270", 16'sd16384, 4'd0, 1'b1, TOL_DIRECTED);
    runSample("quadWrap", 16'sd16384, 4'd0, 1'b0, TOL_DIRECTED);

    // Deviation shift and negative wrap
    runSample("shift15", -16'sd32768, 4'd15, 1'b0, TOL_DIRECTED);
    checkExact("phaseWrap", 64'(modelPhase), 64'd65535);
    runSample("backToZero", 16'sd1, 4'd0, 1'b0, TOL_DIRECTED);
    runSample("negHalf", -16'sd32768, 4'd0, 1'b1, TOL_DIRECTED);

    // Randomized samples
    for (int k = 0; k < 8; k++) begin
      runSample($sformatf("rand%0d", k), 16'($urandom), 4'($urandom_range(0, 6)),
                1'($urandom), TOL_RANDOM);
    end

    // Latency and throughput with tvalid held continuously
    m00Tready = 1'b1;
    s00Tdata  = {16'($urandom), 16'($urandom)};
    sw        = 4'($urandom_range(0, 4));
    s00Tlast  = 1'($urandom);
    s00Tvalid = 1'b1;
    cycle = 0;
    for (int c = 0; c < 200 && validCyc.size() < 3; c++) begin
      acceptNext = s00Tvalid && s00Tready;
      @(posedge clk); #1;
      cycle++;
      if (acceptNext) begin
        modelPhase = advancePhase(modelPhase, s00Tdata[15:0], sw);
        phaseQ.push_back(modelPhase);
        lastQ.push_back(s00Tlast);
        acceptCyc.push_back(cycle);
        s00Tdata = {16'($urandom), 16'($urandom)};
        sw       = 4'($urandom_range(0, 4));
        s00Tlast = ~lastQ[lastQ.size()-1];
        if (acceptCyc.size() == 3) s00Tvalid = 1'b0;
      end
      if (m00Tvalid === 1'b1) begin
        validCyc.push_back(cycle);
        if (phaseQ.size() > 0) begin
          checkOutput($sformatf("stream%0d", validCyc.size()), phaseQ.pop_front(),
                      TOL_RANDOM, lastQ.pop_front());
        end
      end
    end
    s00Tvalid = 1'b0;
    checkExact("streamCount", 64'(validCyc.size()), 64'd3);
    if (validCyc.size() == 3 && acceptCyc.size() == 3) begin
      checkExact("streamLatency", 64'(validCyc[0] - acceptCyc[0]), 64'(LATENCY));
      checkExact("streamAccPeriod", 64'(acceptCyc[2] - acceptCyc[1]), 64'(PERIOD));
      checkExact("streamOutPeriod1", 64'(validCyc[1] - validCyc[0]), 64'(PERIOD));
      checkExact("streamOutPeriod2", 64'(validCyc[2] - validCyc[1]), 64'(PERIOD));
    end
    @(posedge clk); #1;

    // Backpressure: stall the output for 10 cycles
    m00Tready = 1'b0;
    applyStimulus(16'($urandom), 4'($urandom_range(0, 3)), 1'b1);
    waitForOutput("stall");
    checkOutput("stall", modelPhase, TOL_RANDOM, 1'b1);
    heldData = m00Tdata;
    heldLast = m00Tlast;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkExact($sformatf("stallHold%0d", c),
                 64'({m00Tvalid, m00Tlast, m00Tdata, m00Tstrb, s00Tready}),
                 64'({1'b1, heldLast, heldData, 4'hF, 1'b0}));
    end
    m00Tready = 1'b1;
    @(posedge clk); #1;
    checkExact("stallRelease", 64'({m00Tvalid, s00Tready}), 64'(2'b01));
    runSample("afterStall", 16'($urandom), 4'($urandom_range(0, 3)), 1'b0, TOL_RANDOM);

    // Reset in the middle of a rotation
    applyStimulus(16'($urandom), 4'd0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    checkExact("midRotNotValid", 64'(m00Tvalid), 64'(1'b0));
    aresetn = 1'b0;
    #1;
    checkExact("midRotResetOutputs",
               64'({m00Tvalid, m00Tlast, m00Tdata, m00Tstrb, s00Tready}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn    = 1'b1;
    modelPhase = 0;
    rises = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (m00Tvalid === 1'b1) rises++;
    end
    checkExact("midRotNoOutput", 64'(rises), 64'd0);
    runSample("afterMidRot", 16'sd0, 4'd0, 1'b0, TOL_DIRECTED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_modulate.md
# fm_modulate

Transmit-side FM modulator. It takes a stream of signed audio samples over AXI-Stream, integrates them into a 16-bit phase accumulator, and converts each phase to an I/Q pair with an iterative rotation-mode CORDIC. It is the inverse of the receive chain (vectoring CORDIC followed by phase-difference demodulation): its output, fed back into that chain, reproduces the audio scaled by the deviation setting.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32, input stream width
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width
- ITERS, 16, CORDIC iterations (range 1..16)

Ports:
- s00_axis_aclk  in  1  sole clock; everything is on its rising edge
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  1  input sample valid
- s00_axis_tlast  in  1  input packet end
- s00_axis_tdata  in  32  [15:0] signed audio sample; [31:16] ignored
- s00_axis_tstrb  in  4  ignored
- s00_axis_tready  out  1  input ready
- m00_axis_tready  in  1  downstream ready
- sw  in  4  deviation shift; sampled when an input sample is accepted
- m00_axis_tvalid  out  1  output valid
- m00_axis_tlast  out  1  copy of the accepted input tlast
- m00_axis_tdata  out  32  [31:16] Q (signed), [15:0] I (signed)
- m00_axis_tstrb  out  4  4'hF whenever tvalid=1; 0 otherwise

## Operation
- **Phase units:** 16-bit unsigned; 65536 = 2π. Same angle format as the receive CORDIC's angle output.
- **Accept:** an input sample is accepted when s00_axis_tvalid && s00_axis_tready.
  - phase <= phase + (audio >>> sw) (arithmetic shift), truncated to 16 bits; wraps modulo 65536.
  - The updated phase is the angle rotated for that sample.
- **Quadrant pre-rotation (at accept):**
  - If phase[15]^phase[14]=1: x0 = -19896, z0 = phase - 32768.
  - Otherwise: x0 = +19896, z0 = phase.
  - In both cases y0 = 0, and z0 is interpreted as signed 16-bit in [-16384, 16383].
- **Datapath widths:** x and y are 18-bit signed internally; z is 17-bit signed.
- **Iteration i (0..ITERS-1):**
  - d = (z >= 0) ? +1 : -1
  - x <= x - d*(y>>>i)
  - y <= y + d*(x>>>i)
  - z <= z - d*atan[i]
- **atan table (i=0..15):** 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- **Output:** I = sat16(x), Q = sat16(y), saturating to [-32768, 32767]. CORDIC gain about 1.6468 makes the nominal amplitude about 32764.
- **FSM states:**
  - IDLE: s00_axis_tready=1. On accept, go to ROT with iteration counter = 0.
  - ROT: one iteration per cycle. After iteration ITERS-1, go to OUT.
  - OUT: m00_axis_tvalid=1 and tdata/tlast held. When m00_axis_tready=1, go to IDLE.
- **Single sample in flight:** s00_axis_tready=0 in ROT and OUT, so the phase never advances under backpressure.

## Timing
- **Reset (aresetn low):** takes effect immediately, asynchronously, including in the middle of ROT or OUT. The in-flight sample is discarded.
  - State = IDLE, phase = 0, iteration counter = 0.
  - m00_axis_tvalid = 0, m00_axis_tlast = 0, m00_axis_tdata = 0, m00_axis_tstrb = 0.
  - s00_axis_tready = 0 while reset is asserted. It is 1 from the first cycle after release.
- **Latency:** sample accepted at edge 0; iterations occur on edges 1..ITERS; m00_axis_tvalid is high from the cycle following edge ITERS.
  - With ITERS=16, output is valid 16 cycles after acceptance.
- **Throughput:** minimum ITERS+2 cycles per sample (IDLE + ITERS + OUT) with tready held high.
- **OUT/IDLE handover:** on the OUT→IDLE edge, tvalid drops the next cycle. s00_axis_tready rises in that same cycle, with no combinational path from m00 to s00.
- **Backpressure:** during OUT, tdata, tlast and tstrb are stable until the handshake completes.

## Test plan
- **Reset:**
  - Stimulus: assert aresetn low.
  - Response: all outputs 0, and s00_axis_tready = 0 while asserted.
  - After release: s00_axis_tready = 1, and the first sample with audio=0, sw=0 produces I = 32764±4, Q = 0±4.
- **Quadrant walk:**
  - Stimulus: audio=16384, sw=0, four samples.
  - Response, in order:
    - (I,Q) ≈ (0, 32764)
    - (-32764, 0)
    - (0, -32764)
    - (32764, 0) after wrap to phase 0
  - Tolerance ±4 on each value.
- **Deviation shift and negative wrap:**
  - Stimulus: audio=-32768, sw=15, one sample.
  - Response: phase becomes 65535; output I ≈ 32764, Q ≈ -3±4.
  - Stimulus: audio=-32768, sw=0, from phase 0.
  - Response: phase becomes 32768; output (-32764, 0).
- **Latency and throughput:**
  - Stimulus: continuous tvalid with m00_axis_tready tied high.
  - Response: first tvalid exactly 16 cycles after the first accept; one output every 18 cycles; tlast reproduced per sample.
- **Backpressure:**
  - Stimulus: hold m00_axis_tready low for 10 cycles during OUT.
  - Response:
    - tdata, tvalid and tlast stay constant.
    - s00_axis_tready stays 0.
    - The next sample's phase is computed from the pre-stall phase.
- **Reset mid-ROT:**
  - Stimulus: drop aresetn after iteration 8.
  - Response: tvalid never rises for that sample; phase = 0.
  - The next sample after release matches the first-sample-after-reset result.
